std_mult_seq: RTL and testbench
===============================

Name: std_mult_seq

Overview:
- Callee-side (responder) end of the valid/ready control handshake: a multi-cycle shift-add multiplier.
- Controller FSMs drive `valid` and wait for `ready`. This block samples `valid`, computes the product over several cycles, then pulses `ready`.
- Instantiated as a leaf primitive next to `std_reg`/`std_const`. Used wherever a group enables a multiply.

Parameters:
- `WIDTH`, default 32, operand and result width in bits (legal 2..64).

Ports:
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `valid` input 1: go request from controller; held high until `ready` is sampled.
- `left` input `WIDTH`: multiplicand; sampled only on the accept cycle.
- `right` input `WIDTH`: multiplier; sampled only on the accept cycle.
- `out` output `WIDTH`: registered product mod 2^WIDTH.
- `ready` output 1: done pulse; high for exactly one cycle per operation.

Behaviour:
- Interface: reset `reset`, synchronous, active-high; clock `clk`.
- Reset values: state=IDLE, `ready`=0, `out`=0, internal accumulator/shift registers/counter=0.
- Reset has priority over every other condition, including mid-operation. An in-flight operation is discarded; `out` returns to 0.
- States: IDLE, BUSY, DONE, DRAIN. Encoding is free; use a registered state machine with a separate next-state block.
- IDLE:
  - If `valid`=1 at the edge: latch `a`=`left`, `b`=`right`, `acc`=0, `cnt`=0, then go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, one step per cycle:
  - If `b[0]`, then `acc` <= `acc` + `a` (mod 2^WIDTH).
  - `a` <= `a` << 1; `b` <= `b` >> 1; `cnt` <= `cnt` + 1.
  - After the step with `cnt`=WIDTH-1, go to DONE and load `out` <= final `acc`.
  - `valid` is ignored while BUSY. Dropping it does not abort the operation.
- DONE:
  - `ready`=1 for this single cycle; `out` already holds the result.
  - Next state is IDLE if `valid`=0, else DRAIN.
- DRAIN:
  - `ready`=0; wait until `valid`=0, then go to IDLE.
  - Guarantees a `valid` still high from the finished request never starts a second operation.
- Latency: `valid` accepted at edge t, then WIDTH BUSY cycles. `ready`=1 in cycle t+WIDTH+1. WIDTH=32 gives 33 cycles from accept to `ready`.
- `out` changes only on the BUSY->DONE transition or on reset. It is held stable through DRAIN, IDLE and the next operation's BUSY phase.
- `ready` is a registered function of state only; no combinational path from `valid` to `ready`.
- Arithmetic is unsigned. Overflow bits above WIDTH are discarded (low WIDTH bits of the full product).
- `cnt` width is clog2(WIDTH)+1; wrap-around is never reached.
- Back-to-back: if the controller lowers `valid` during DONE and raises it again the next cycle, that cycle is IDLE. Acceptance happens there, so the minimum initiation interval is WIDTH+2 cycles.

Optional Feature:
- Macro: `STD_MULT_SEQ_EARLY_EXIT_EN`.
- Defined: in BUSY, leave for DONE after the first step whose shifted `b` equals 0, or at `cnt`=WIDTH-1, whichever comes first.
  - BUSY length = max(1, bit-length(`right`)), so `right`=0 takes 1 cycle.
  - `ready` occurs at t+1+BUSY length.
- Undefined: fixed latency of WIDTH BUSY cycles as above.
- Result values are identical in both builds.

Test Plan:
- Reset then idle 5 cycles with `valid`=0 -> `ready`=0 and `out`=0 every cycle; state stays IDLE.
- WIDTH=32, `left`=7, `right`=6, `valid` held until `ready` -> `ready` high exactly in cycle t+33, `out`=42; `out` stays 42 for 10 idle cycles; `valid` still high in DONE gives no restart (DRAIN).
- `left`=0xFFFFFFFF, `right`=2 -> `out`=0xFFFFFFFE (overflow truncated); `left`=0x10000, `right`=0x10000 -> `out`=0.
- Assert `reset` at BUSY cycle 10 of an operation -> next cycle `out`=0, `ready`=0, IDLE; a fresh `valid` with 3*5 -> `out`=15 after 33 cycles.
- Two back-to-back operations (3*4, then 9*9), with `valid` lowered in the DONE cycle and raised the following cycle -> `ready` pulses 34 cycles apart; `out`=12 then 81; `out` holds 12 during the second BUSY phase.
- With `STD_MULT_SEQ_EARLY_EXIT_EN`: `right`=5 -> `ready` at t+4, `out`=5*`left`; `right`=0 -> `ready` at t+2, `out`=0; `right`=0x80000000 -> `ready` at t+33.

Source files
------------

// File: rtl/std_mult_seq.sv
// ============================================================================
// Module   : std_mult_seq
// Brief    : Multi-cycle unsigned shift-add multiplier, valid/ready responder.
//            Optional macro STD_MULT_SEQ_EARLY_EXIT_EN ends BUSY once the
//            multiplier has no set bits left.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module std_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid,
    input  logic [WIDTH-1:0] left,
    input  logic [WIDTH-1:0] right,
    output logic [WIDTH-1:0] out,
    output logic             ready
);

    localparam int                 c_CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DONE  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_out;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ready;

    logic [WIDTH-1:0]   w_acc_step;
    logic [WIDTH-1:0]   w_b_shift;
    logic               w_last_cnt;
    logic               w_busy_end;

    assign w_acc_step = r_b[0] ? (r_acc + r_a) : r_acc;
    assign w_b_shift  = r_b >> 1;
    assign w_last_cnt = (r_cnt == c_LAST_CNT);

`ifdef STD_MULT_SEQ_EARLY_EXIT_EN
    // No remaining multiplier bits means later steps cannot change acc.
    assign w_busy_end = w_last_cnt || (w_b_shift == '0);
`else
    assign w_busy_end = w_last_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (valid) w_state_next = S_BUSY;
            S_BUSY:  if (w_busy_end) w_state_next = S_DONE;
            // A valid still held from the finished request must not restart.
            S_DONE:  w_state_next = valid ? S_DRAIN : S_IDLE;
            S_DRAIN: if (!valid) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_ready <= (w_state_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (valid) begin
                        r_a   <= left;
                        r_b   <= right;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_BUSY: begin
                    r_acc <= w_acc_step;
                    r_a   <= r_a << 1;
                    r_b   <= w_b_shift;
                    r_cnt <= r_cnt + c_CNT_ONE;
                    if (w_busy_end) begin
                        r_out <= w_acc_step;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign out   = r_out;
    assign ready = r_ready;

endmodule

`default_nettype wire

// File: tb/tb_std_mult_seq.sv
// ============================================================================
// Module   : tb_std_mult_seq
// Brief    : Directed self-checking bench for std_mult_seq (WIDTH=32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_std_mult_seq;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             valid;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic [WIDTH-1:0] out;
    logic             ready;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    int               op_lat;
    int               op_ready_cyc;
    logic [WIDTH-1:0] op_out;
    bit               op_timeout;
    bit               op_out_moved;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    std_mult_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .valid (valid),
        .left  (left),
        .right (right),
        .out   (out),
        .ready (ready)
    );

    // Called just after a negedge with the DUT idle. Latency is counted from
    // the accept cycle (t) to the cycle where ready is seen high.
    task automatic run_op(input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r,
                          input bit drop_in_done);
        int               t0;
        logic [WIDTH-1:0] out0;
        op_timeout   = 1'b1;
        op_out_moved = 1'b0;
        op_lat       = -1;
        op_out       = '0;
        out0         = out;
        valid        = 1'b1;
        left         = l;
        right        = r;
        t0           = cyc;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 0) begin
                left  = ~l;
                right = ~r;
            end
            if (ready === 1'b1) begin
                op_timeout   = 1'b0;
                op_lat       = cyc - t0;
                op_ready_cyc = cyc;
                op_out       = out;
                break;
            end
            if (out !== out0) op_out_moved = 1'b1;
        end
        if (drop_in_done) valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        valid = 1'b0;
        left  = '0;
        right = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ready[%0d]: got %b expected 0", i, ready);
            end
            n_checks++;
            if (out !== '0) begin
                n_fail++;
                $display("FAIL reset_out[%0d]: got %h expected 0", i, out);
            end
        end
    endtask

    task automatic test_basic();
        run_op(32'd7, 32'd6, 1'b0);
        n_checks++;
        if (op_timeout) begin
            n_fail++;
            $display("FAIL basic_timeout: got no ready expected ready within 200 cycles");
        end
        n_checks++;
        if (op_lat != 33) begin
            n_fail++;
            $display("FAIL basic_lat: got %0d expected 33", op_lat);
        end
        n_checks++;
        if (op_out !== 32'd42) begin
            n_fail++;
            $display("FAIL basic_out: got %0d expected 42", op_out);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b0 || out !== 32'd42) begin
                n_fail++;
                $display("FAIL drain[%0d]: got ready=%b out=%0d expected ready=0 out=42", i, ready, out);
            end
        end
        valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            n_checks++;
            if (ready !== 1'b0 || out !== 32'd42) begin
                n_fail++;
                $display("FAIL idle_hold[%0d]: got ready=%b out=%0d expected ready=0 out=42", i, ready, out);
            end
        end
    endtask

    task automatic test_overflow();
        run_op(32'h0001_0000, 32'h0001_0000, 1'b1);
        n_checks++;
        if (op_timeout || op_lat != 33 || op_out !== 32'h0) begin
            n_fail++;
            $display("FAIL ovf_zero: got lat=%0d out=%h expected lat=33 out=00000000", op_lat, op_out);
        end
        @(negedge clk);
        run_op(32'hFFFF_FFFF, 32'd2, 1'b1);
        n_checks++;
        if (op_timeout || op_lat != 33 || op_out !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL ovf_trunc: got lat=%0d out=%h expected lat=33 out=fffffffe", op_lat, op_out);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        valid = 1'b1;
        left  = 32'h1234;
        right = 32'h5678;
        repeat (10) @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || out !== 32'hFFFF_FFFE) begin
            n_fail++;
            $display("FAIL busy_hold: got ready=%b out=%h expected ready=0 out=fffffffe", ready, out);
        end
        reset = 1'b1;
        valid = 1'b0;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || out !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: got ready=%b out=%h expected ready=0 out=0", ready, out);
        end
        reset = 1'b0;
        @(negedge clk);
        run_op(32'd3, 32'd5, 1'b1);
        n_checks++;
        if (op_timeout || op_lat != 33 || op_out !== 32'd15) begin
            n_fail++;
            $display("FAIL after_reset: got lat=%0d out=%0d expected lat=33 out=15", op_lat, op_out);
        end
    endtask

    task automatic test_back_to_back();
        int r1;
        @(negedge clk);
        run_op(32'd3, 32'd4, 1'b1);
        r1 = op_ready_cyc;
        n_checks++;
        if (op_timeout || op_out !== 32'd12) begin
            n_fail++;
            $display("FAIL b2b_first: got out=%0d expected 12", op_out);
        end
        @(negedge clk);
        run_op(32'd9, 32'd9, 1'b1);
        n_checks++;
        if (op_out_moved) begin
            n_fail++;
            $display("FAIL b2b_hold: got out changed during BUSY expected held at 12");
        end
        n_checks++;
        if (op_timeout || (op_ready_cyc - r1) != 34) begin
            n_fail++;
            $display("FAIL b2b_gap: got %0d expected 34", op_ready_cyc - r1);
        end
        n_checks++;
        if (op_out !== 32'd81) begin
            n_fail++;
            $display("FAIL b2b_second: got out=%0d expected 81", op_out);
        end
    endtask

    task automatic test_early_exit();
`ifdef STD_MULT_SEQ_EARLY_EXIT_EN
        int lat5 = 4, lat0 = 2, lat1 = 2;
`else
        int lat5 = 33, lat0 = 33, lat1 = 33;
`endif
        @(negedge clk);
        run_op(32'd11, 32'd5, 1'b1);
        n_checks++;
        if (op_timeout || op_lat != lat5 || op_out !== 32'd55) begin
            n_fail++;
            $display("FAIL ee_r5: got lat=%0d out=%0d expected lat=%0d out=55", op_lat, op_out, lat5);
        end
        @(negedge clk);
        run_op(32'd123, 32'd0, 1'b1);
        n_checks++;
        if (op_timeout || op_lat != lat0 || op_out !== 32'd0) begin
            n_fail++;
            $display("FAIL ee_r0: got lat=%0d out=%0d expected lat=%0d out=0", op_lat, op_out, lat0);
        end
        @(negedge clk);
        run_op(32'hDEAD_BEEF, 32'd1, 1'b1);
        n_checks++;
        if (op_timeout || op_lat != lat1 || op_out !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL ee_r1: got lat=%0d out=%h expected lat=%0d out=deadbeef", op_lat, op_out, lat1);
        end
        @(negedge clk);
        run_op(32'd3, 32'h8000_0000, 1'b1);
        n_checks++;
        if (op_timeout || op_lat != 33 || op_out !== 32'h8000_0000) begin
            n_fail++;
            $display("FAIL ee_rmsb: got lat=%0d out=%h expected lat=33 out=80000000", op_lat, op_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        test_early_exit();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
